// File: rtl/fft64_pkg.sv
// Shared definitions for the FFT64 scheduler.
//   state_t   : scheduler FSM states
//   FFT_N     : samples (and results) per frame
//   IDX_W     : width of a beat index within a frame
//   LAT_LIMIT_DEF : default latency/gap watchdog limit in cycles
//   bitrev()  : reverses the bits of a beat index (radix-2 output reorder)
package fft64_pkg;

  localparam int FFT_N         = 64;
  localparam int IDX_W         = $clog2(FFT_N);
  localparam int LAT_LIMIT_DEF = 130;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_DRAIN,
    ST_RECOVER
  } state_t;

  function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int b = 0; b < IDX_W; b++) begin
      r[b] = v[IDX_W-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft64_rr_arb.sv
// Combinational round-robin pick.
//   req       : per-requester request level
//   rr_ptr    : requester that currently has highest priority
//   win_oh    : one-hot winner (all zero when nobody requests)
//   win_ch    : binary index of the winner
//   win_valid : at least one requester is asking
module fft64_rr_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         win_oh,
  output logic [$clog2(NUM_REQ)-1:0] win_ch,
  output logic                       win_valid
);

  localparam int CH_W = $clog2(NUM_REQ);

  // cand[k] is the channel sitting k places after rr_ptr, wrapping at NUM_REQ.
  logic [CH_W-1:0] cand [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [CH_W:0] sum;
      assign sum = {1'b0, rr_ptr} + (CH_W+1)'(gi);
      assign cand[gi] = (sum >= (CH_W+1)'(NUM_REQ)) ? CH_W'(sum - (CH_W+1)'(NUM_REQ))
                                                    : sum[CH_W-1:0];
    end
  endgenerate

  // Scan from the farthest candidate back to the nearest so the nearest
  // requesting channel is the last (and therefore winning) assignment.
  always_comb begin
    win_valid = 1'b0;
    win_ch    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        win_valid = 1'b1;
        win_ch    = cand[k];
      end
    end
  end

  assign win_oh = win_valid ? (NUM_REQ'(1) << win_ch) : '0;

endmodule

// File: rtl/fft64_sched.sv
// Round-robin scheduler sharing one FFT64 core between NUM_REQ requesters.
// One requester is granted per frame; its FFT_N samples are forwarded to the
// core, the core's results are returned tagged with channel and beat index.
// Underrun or a latency/gap timeout aborts the frame and pulses fft_rst_n.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req/gnt              : per-requester frame request / one-hot grant
//   s_valid/s_r/s_i      : per-requester sample streams (packed by channel)
//   fft_rst_n            : core reset, active-low
//   fft_in_valid/din_*   : samples to the core (registered copy of granted stream)
//   fft_out_valid/dout_* : results from the core
//   m_valid/m_r/m_i/m_ch/m_idx/m_last : tagged result stream
//   busy                 : scheduler not idle
//   err_underrun/err_timeout : sticky error flags
//
// Build option: define FFT64_SCHED_BITREV_IDX_EN to report m_idx as the
// bit-reversed beat count (natural bin for radix-2 bit-reversed output order);
// otherwise m_idx is the arrival-order beat count.
module fft64_sched
  import fft64_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int IN_W      = 12,
  parameter int OUT_W     = 16,
  parameter int LAT_LIMIT = LAT_LIMIT_DEF,
  parameter int RST_CYC   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic [NUM_REQ-1:0]         s_valid,
  input  logic [NUM_REQ*IN_W-1:0]    s_r,
  input  logic [NUM_REQ*IN_W-1:0]    s_i,
  output logic                       fft_rst_n,
  output logic                       fft_in_valid,
  output logic [IN_W-1:0]            fft_din_r,
  output logic [IN_W-1:0]            fft_din_i,
  input  logic                       fft_out_valid,
  input  logic [OUT_W-1:0]           fft_dout_r,
  input  logic [OUT_W-1:0]           fft_dout_i,
  output logic                       m_valid,
  output logic [OUT_W-1:0]           m_r,
  output logic [OUT_W-1:0]           m_i,
  output logic [$clog2(NUM_REQ)-1:0] m_ch,
  output logic [IDX_W-1:0]           m_idx,
  output logic                       m_last,
  output logic                       busy,
  output logic                       err_underrun,
  output logic                       err_timeout
);

  localparam int CH_W  = $clog2(NUM_REQ);
  localparam int LAT_W = $clog2(LAT_LIMIT + 1);
  localparam int RST_W = $clog2(RST_CYC + 1);

  state_t state_reg, state_next;

  logic [NUM_REQ-1:0] gnt_reg;
  logic [CH_W-1:0]    cur_ch_reg, rr_ptr_reg;
  logic [IDX_W-1:0]   in_cnt_reg, out_cnt_reg;
  logic [LAT_W-1:0]   lat_cnt_reg;
  logic [RST_W-1:0]   rstp_cnt_reg;
  logic               fft_in_valid_reg;
  logic [IN_W-1:0]    fft_din_r_reg, fft_din_i_reg;
  logic               m_valid_reg, m_last_reg;
  logic [OUT_W-1:0]   m_r_reg, m_i_reg;
  logic [CH_W-1:0]    m_ch_reg;
  logic [IDX_W-1:0]   m_idx_reg;
  logic               err_underrun_reg, err_timeout_reg;

  logic [NUM_REQ-1:0] win_oh;
  logic [CH_W-1:0]    win_ch;
  logic               win_valid;

  fft64_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_reg),
    .win_oh    (win_oh),
    .win_ch    (win_ch),
    .win_valid (win_valid)
  );

  // Granted channel's stream; other channels are never looked at.
  logic            sv_sel;
  logic [IN_W-1:0] sr_sel, si_sel;
  assign sv_sel = s_valid[cur_ch_reg];
  assign sr_sel = s_r[int'(cur_ch_reg) * IN_W +: IN_W];
  assign si_sel = s_i[int'(cur_ch_reg) * IN_W +: IN_W];

  logic load_beat, load_done, underrun, out_beat, drain_done, lat_expire, in_core_phase;
  assign load_beat     = (state_reg == ST_LOAD) && sv_sel;
  assign load_done     = load_beat && (in_cnt_reg == IDX_W'(FFT_N - 1));
  // in_cnt != 0 means the first beat has been seen; idle cycles before it are fine.
  assign underrun      = (state_reg == ST_LOAD) && !sv_sel && (in_cnt_reg != '0);
  assign in_core_phase = (state_reg == ST_WAIT) || (state_reg == ST_DRAIN);
  assign out_beat      = in_core_phase && fft_out_valid;
  assign drain_done    = out_beat && (out_cnt_reg == IDX_W'(FFT_N - 1));
  // Fires on the cycle the silent-cycle count would reach LAT_LIMIT.
  assign lat_expire    = in_core_phase && !fft_out_valid && (lat_cnt_reg == LAT_W'(LAT_LIMIT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:    if (win_valid) state_next = ST_LOAD;
      ST_LOAD:    if (load_done) state_next = ST_WAIT;
                  else if (underrun) state_next = ST_RECOVER;
      // The first out_valid beat is captured in WAIT as result 0.
      ST_WAIT:    if (out_beat) state_next = ST_DRAIN;
                  else if (lat_expire) state_next = ST_RECOVER;
      ST_DRAIN:   if (drain_done) state_next = ST_IDLE;
                  else if (lat_expire) state_next = ST_RECOVER;
      ST_RECOVER: if (rstp_cnt_reg <= RST_W'(1)) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs derived from state
  always_comb begin
    busy      = (state_reg != ST_IDLE);
    fft_rst_n = (rstp_cnt_reg == '0);
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_reg          <= '0;
      cur_ch_reg       <= '0;
      rr_ptr_reg       <= '0;
      in_cnt_reg       <= '0;
      out_cnt_reg      <= '0;
      lat_cnt_reg      <= '0;
      rstp_cnt_reg     <= RST_W'(RST_CYC);
      fft_in_valid_reg <= 1'b0;
      fft_din_r_reg    <= '0;
      fft_din_i_reg    <= '0;
      m_valid_reg      <= 1'b0;
      m_last_reg       <= 1'b0;
      m_r_reg          <= '0;
      m_i_reg          <= '0;
      m_ch_reg         <= '0;
      m_idx_reg        <= '0;
      err_underrun_reg <= 1'b0;
      err_timeout_reg  <= 1'b0;
    end else begin
      m_valid_reg      <= 1'b0;
      m_last_reg       <= 1'b0;
      fft_in_valid_reg <= load_beat;
      if (rstp_cnt_reg != '0) begin
        rstp_cnt_reg <= rstp_cnt_reg - 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (win_valid) begin
            gnt_reg    <= win_oh;
            cur_ch_reg <= win_ch;
            rr_ptr_reg <= (win_ch == CH_W'(NUM_REQ - 1)) ? '0 : win_ch + 1'b1;
            in_cnt_reg <= '0;
          end
        end
        ST_LOAD: begin
          if (load_beat) begin
            fft_din_r_reg <= sr_sel;
            fft_din_i_reg <= si_sel;
            in_cnt_reg    <= in_cnt_reg + 1'b1;
          end
          if (load_done) begin
            gnt_reg     <= '0;
            lat_cnt_reg <= '0;
            out_cnt_reg <= '0;
          end
          if (underrun) begin
            gnt_reg          <= '0;
            err_underrun_reg <= 1'b1;
            rstp_cnt_reg     <= RST_W'(RST_CYC);
          end
        end
        ST_WAIT, ST_DRAIN: begin
          if (out_beat) begin
            m_valid_reg <= 1'b1;
            m_r_reg     <= fft_dout_r;
            m_i_reg     <= fft_dout_i;
            m_ch_reg    <= cur_ch_reg;
`ifdef FFT64_SCHED_BITREV_IDX_EN
            m_idx_reg   <= bitrev(out_cnt_reg);
`else
            m_idx_reg   <= out_cnt_reg;
`endif
            m_last_reg  <= (out_cnt_reg == IDX_W'(FFT_N - 1));
            out_cnt_reg <= out_cnt_reg + 1'b1;
            lat_cnt_reg <= '0;
          end else if (lat_expire) begin
            err_timeout_reg <= 1'b1;
            rstp_cnt_reg    <= RST_W'(RST_CYC);
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 1'b1;
          end
        end
        ST_RECOVER: begin
          in_cnt_reg  <= '0;
          out_cnt_reg <= '0;
          lat_cnt_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign gnt          = gnt_reg;
  assign fft_in_valid = fft_in_valid_reg;
  assign fft_din_r    = fft_din_r_reg;
  assign fft_din_i    = fft_din_i_reg;
  assign m_valid      = m_valid_reg;
  assign m_r          = m_r_reg;
  assign m_i          = m_i_reg;
  assign m_ch         = m_ch_reg;
  assign m_idx        = m_idx_reg;
  assign m_last       = m_last_reg;
  assign err_underrun = err_underrun_reg;
  assign err_timeout  = err_timeout_reg;

endmodule

// File: tb/tb_fft64_sched.sv
// Directed testbench for fft64_sched: single frame, round-robin order,
// underrun, timeout, drain gaps and reset during drain.
module tb_fft64_sched;
  import fft64_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int IN_W    = 12;
  localparam int OUT_W   = 16;
  localparam int CH_W    = $clog2(NUM_REQ);

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req, gnt, s_valid;
  logic [NUM_REQ*IN_W-1:0] s_r, s_i;
  logic                    fft_rst_n, fft_in_valid;
  logic [IN_W-1:0]         fft_din_r, fft_din_i;
  logic                    fft_out_valid;
  logic [OUT_W-1:0]        fft_dout_r, fft_dout_i;
  logic                    m_valid, m_last, busy, err_underrun, err_timeout;
  logic [OUT_W-1:0]        m_r, m_i;
  logic [CH_W-1:0]         m_ch;
  logic [IDX_W-1:0]        m_idx;

  fft64_sched #(.NUM_REQ(NUM_REQ), .IN_W(IN_W), .OUT_W(OUT_W), .LAT_LIMIT(130), .RST_CYC(2)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .s_valid(s_valid), .s_r(s_r), .s_i(s_i),
    .fft_rst_n(fft_rst_n), .fft_in_valid(fft_in_valid), .fft_din_r(fft_din_r), .fft_din_i(fft_din_i),
    .fft_out_valid(fft_out_valid), .fft_dout_r(fft_dout_r), .fft_dout_i(fft_dout_i),
    .m_valid(m_valid), .m_r(m_r), .m_i(m_i), .m_ch(m_ch), .m_idx(m_idx), .m_last(m_last),
    .busy(busy), .err_underrun(err_underrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus and reference values
  function automatic logic [IN_W-1:0] samp_r(input int k);
    return IN_W'((k * 37 + 5) % 4096);
  endfunction
  function automatic logic [IN_W-1:0] samp_i(input int k);
    return IN_W'(4095 - 3 * k);
  endfunction
  function automatic logic [OUT_W-1:0] res_r(input int k);
    return OUT_W'(4096 + 7 * k);
  endfunction
  function automatic logic [OUT_W-1:0] res_i(input int k);
    return OUT_W'(32768 + 3 * k);
  endfunction
  function automatic logic [IDX_W-1:0] exp_idx(input int k);
    logic [IDX_W-1:0] v, o;
    v = IDX_W'(k);
`ifdef FFT64_SCHED_BITREV_IDX_EN
    for (int b = 0; b < IDX_W; b++) o[b] = v[IDX_W-1-b];
`else
    o = v;
`endif
    return o;
  endfunction

  // Monitor: result capture, counters, and a registered-copy model of the core input
  typedef struct packed {
    logic [OUT_W-1:0] r;
    logic [OUT_W-1:0] i;
    logic [CH_W-1:0]  ch;
    logic [IDX_W-1:0] idx;
    logic             last;
  } mrec_t;

  mrec_t              mq[$];
  int                 busy_q[$];
  logic [NUM_REQ-1:0] gnt_q[$];
  int                 in_beats = 0, rstn_low = 0, busy_run = 0;
  logic               busy_prev = 1'b0, chk_en = 1'b0, exp_iv = 1'b0;
  logic [NUM_REQ-1:0] gnt_prev = '0;
  logic [IN_W-1:0]    exp_r = '0, exp_i = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("in_valid", fft_in_valid, exp_iv);
      if (exp_iv) begin
        check_eq("din_r", fft_din_r, exp_r);
        check_eq("din_i", fft_din_i, exp_i);
      end
    end
    exp_iv = 1'b0;
    for (int c = 0; c < NUM_REQ; c++) begin
      if (gnt[c] === 1'b1 && s_valid[c] === 1'b1 && rst === 1'b0) begin
        exp_iv = 1'b1;
        exp_r  = s_r[c*IN_W +: IN_W];
        exp_i  = s_i[c*IN_W +: IN_W];
      end
    end
    if (m_valid === 1'b1) mq.push_back(mrec_t'{m_r, m_i, m_ch, m_idx, m_last});
    if (fft_in_valid === 1'b1) in_beats++;
    if (fft_rst_n === 1'b0) rstn_low++;
    if (busy === 1'b1 && !busy_prev) busy_q.push_back(busy_run);
    busy_run  = (busy === 1'b1) ? 0 : busy_run + 1;
    busy_prev = (busy === 1'b1);
    if ((|gnt) === 1'b1 && gnt_prev == '0) gnt_q.push_back(gnt);
    gnt_prev = ((|gnt) === 1'b1) ? gnt : '0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    mq.delete();
    busy_q.delete();
    gnt_q.delete();
    in_beats = 0;
    rstn_low = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  // Wait for grant of ch, optionally idle `pre` cycles, then send nb contiguous beats.
  task automatic run_load(input int ch, input int nb, input bit drop_req, input int pre);
    int t;
    t = 0;
    while (gnt[ch] !== 1'b1 && t < 40) begin
      tick;
      t++;
    end
    check_eq($sformatf("gnt_ch%0d", ch), gnt, NUM_REQ'(1) << ch);
    if (drop_req) req[ch] = 1'b0;
    repeat (pre) tick;
    for (int k = 0; k < nb; k++) begin
      s_valid[ch]          = 1'b1;
      s_r[ch*IN_W +: IN_W] = samp_r(k);
      s_i[ch*IN_W +: IN_W] = samp_i(k);
      tick;
    end
    s_valid[ch] = 1'b0;
  endtask

  // Core model: silent for `delay` cycles, then nb result beats with an optional pause.
  task automatic core_respond(input int delay, input int nb, input int gap_at, input int gap_len);
    fft_out_valid = 1'b0;
    repeat (delay) tick;
    for (int k = 0; k < nb; k++) begin
      if (k == gap_at) begin
        fft_out_valid = 1'b0;
        repeat (gap_len) tick;
      end
      fft_out_valid = 1'b1;
      fft_dout_r    = res_r(k);
      fft_dout_i    = res_i(k);
      tick;
    end
    fft_out_valid = 1'b0;
  endtask

  task automatic check_results(input string tag, input int ch, input int n);
    check_eq({tag, "_count"}, mq.size(), n);
    for (int k = 0; k < mq.size() && k < n; k++) begin
      check_eq($sformatf("%s_r[%0d]", tag, k), mq[k].r, res_r(k));
      check_eq($sformatf("%s_i[%0d]", tag, k), mq[k].i, res_i(k));
      check_eq($sformatf("%s_ch[%0d]", tag, k), mq[k].ch, ch);
      check_eq($sformatf("%s_idx[%0d]", tag, k), mq[k].idx, exp_idx(k));
      check_eq($sformatf("%s_last[%0d]", tag, k), mq[k].last, (k == 63));
    end
  endtask

  task automatic wait_timeout(input string tag, input int expect_cycles);
    int k;
    k = 0;
    while (err_timeout !== 1'b1 && k < 300) begin
      tick;
      k++;
    end
    check_eq({tag, "_cycles"}, k, expect_cycles);
    check_eq({tag, "_rstn"}, fft_rst_n, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b1);
    tick;
    tick;
    check_eq({tag, "_idle"}, busy, 1'b0);
    check_eq({tag, "_rstn_rel"}, fft_rst_n, 1'b1);
    check_eq({tag, "_rstn_len"}, rstn_low, 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; req = '0; s_valid = '0; s_r = '0; s_i = '0;
    fft_out_valid = 1'b0; fft_dout_r = '0; fft_dout_i = '0;

    // Reset values and core reset pulse
    rst = 1'b1;
    tick;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_last", m_last, 0);
    check_eq("rst_in_valid", fft_in_valid, 0);
    check_eq("rst_err_u", err_underrun, 0);
    check_eq("rst_err_t", err_timeout, 0);
    check_eq("rst_rstn", fft_rst_n, 0);
    rst = 1'b0;
    tick;
    check_eq("rst_rstn_hold", fft_rst_n, 0);
    tick;
    check_eq("rst_rstn_rel", fft_rst_n, 1);
    chk_en = 1'b1;

    // Single frame on ch0, core answers after 70 cycles
    clear_mon();
    req = 2'b01;
    run_load(0, 64, 1'b1, 0);
    core_respond(70, 64, -1, 0);
    tick; tick;
    check_eq("t1_in_beats", in_beats, 64);
    check_results("t1", 0, 64);
    check_eq("t1_busy", busy, 0);
    check_eq("t1_err_t", err_timeout, 0);

    // Round-robin with both requesters held
    do_reset();
    tick; tick;
    clear_mon();
    req = 2'b11;
    run_load(0, 64, 1'b0, 0);
    core_respond(5, 64, -1, 0);
    run_load(1, 64, 1'b0, 0);
    core_respond(5, 64, -1, 0);
    run_load(0, 64, 1'b0, 0);
    req = 2'b00;
    core_respond(5, 64, -1, 0);
    tick; tick;
    check_eq("t2_ngnt", gnt_q.size(), 3);
    if (gnt_q.size() >= 3) begin
      check_eq("t2_gnt0", gnt_q[0], 2'b01);
      check_eq("t2_gnt1", gnt_q[1], 2'b10);
      check_eq("t2_gnt2", gnt_q[2], 2'b01);
    end
    check_eq("t2_nbusy", busy_q.size(), 3);
    if (busy_q.size() >= 3) begin
      check_eq("t2_gap1", busy_q[1], 1);
      check_eq("t2_gap2", busy_q[2], 1);
    end
    check_eq("t2_results", mq.size(), 192);

    // Short pause mid-drain is tolerated
    clear_mon();
    req = 2'b01;
    run_load(0, 64, 1'b1, 0);
    core_respond(40, 64, 32, 10);
    tick; tick;
    check_results("t3", 0, 64);
    check_eq("t3_err_t", err_timeout, 0);
    check_eq("t3_err_u", err_underrun, 0);

    // Underrun on ch1 after 20 beats, then a clean ch0 frame
    clear_mon();
    req = 2'b10;
    run_load(1, 20, 1'b1, 3);
    tick;
    check_eq("t4_err_u", err_underrun, 1);
    check_eq("t4_rstn", fft_rst_n, 0);
    check_eq("t4_gnt", gnt, 0);
    check_eq("t4_busy", busy, 1);
    tick; tick;
    check_eq("t4_idle", busy, 0);
    check_eq("t4_rstn_rel", fft_rst_n, 1);
    check_eq("t4_rstn_len", rstn_low, 2);
    check_eq("t4_in_beats", in_beats, 20);
    check_eq("t4_no_m", mq.size(), 0);
    clear_mon();
    req = 2'b01;
    run_load(0, 64, 1'b1, 0);
    core_respond(70, 64, -1, 0);
    tick; tick;
    check_results("t4b", 0, 64);
    check_eq("t4_err_u_sticky", err_underrun, 1);

    // Core never answers
    clear_mon();
    req = 2'b01;
    run_load(0, 64, 1'b1, 0);
    wait_timeout("t5", 130);
    check_eq("t5_no_m", mq.size(), 0);

    // Sticky flags clear on reset; a 130-cycle drain pause times out
    do_reset();
    check_eq("t6_err_t_clr", err_timeout, 0);
    check_eq("t6_err_u_clr", err_underrun, 0);
    tick; tick;
    clear_mon();
    req = 2'b01;
    run_load(0, 64, 1'b1, 0);
    core_respond(20, 30, -1, 0);
    wait_timeout("t6", 130);
    check_results("t6", 0, 30);

    // Reset while draining ch1 at beat 30
    do_reset();
    tick; tick;
    clear_mon();
    req = 2'b10;
    run_load(1, 64, 1'b1, 0);
    core_respond(20, 30, -1, 0);
    rst = 1'b1;
    fft_out_valid = 1'b1;
    fft_dout_r = res_r(30);
    fft_dout_i = res_i(30);
    tick;
    check_eq("t7_m_valid", m_valid, 0);
    check_eq("t7_m_r", m_r, 0);
    check_eq("t7_m_i", m_i, 0);
    check_eq("t7_m_ch", m_ch, 0);
    check_eq("t7_m_idx", m_idx, 0);
    check_eq("t7_m_last", m_last, 0);
    check_eq("t7_busy", busy, 0);
    check_eq("t7_gnt", gnt, 0);
    check_eq("t7_din_r", fft_din_r, 0);
    check_eq("t7_din_i", fft_din_i, 0);
    check_eq("t7_rstn", fft_rst_n, 0);
    rst = 1'b0;
    repeat (33) tick;
    fft_out_valid = 1'b0;
    tick;
    check_eq("t7_no_extra_m", mq.size(), 30);
    clear_mon();
    req = 2'b10;
    run_load(1, 64, 1'b1, 0);
    core_respond(30, 64, -1, 0);
    tick; tick;
    check_results("t7b", 1, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
